// File: rtl/accelerator_hls_deadlock_pkg.sv
// Shared types for the HLS deadlock report unit: FSM state, report record
// and the lowest-set-bit helper used to pick the reporting monitor.
package accelerator_hls_deadlock_pkg;

    localparam int TS_W      = 32;
    localparam int MAX_MON   = 16;
    localparam int MAX_IDX_W = 16;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        REPORT = 2'd1,
        HALT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_MON-1:0]   mask;
        logic [TS_W-1:0]      timestamp;
    } rpt_t;

    // Lowest index wins when several monitors qualify together.
    function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_MON-1:0] v);
        lowest_set = '0;
        for (int i = MAX_MON - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = MAX_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/accelerator_hls_deadlock_persist_filter.sv
// Persistence filter: a monitor bit qualifies once it has been high for
// PERSIST consecutive cycles; any low cycle or clr restarts the count.
module accelerator_hls_deadlock_persist_filter #(
    parameter int PERSIST = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in,
    output logic qual
);

    localparam int                CNT_W = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(PERSIST);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesized netlist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !in) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign qual = (cnt == LIMIT);

endmodule

// File: rtl/accelerator_hls_deadlock_report_unit.sv
// Deadlock report unit: filters monitor block flags, captures one report record
// and holds a sticky deadlock flag until cleared. Optional cycle timestamp is
// enabled with the ACCEL_DEADLOCK_TIMESTAMP_EN macro.
module accelerator_hls_deadlock_report_unit
    import accelerator_hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int PERSIST = 16,
    parameter int IDX_W   = 4
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [IDX_W-1:0]   rpt_idx,
    output logic [NUM_MON-1:0] rpt_mask,
    output logic [TS_W-1:0]    rpt_timestamp,
    output logic               deadlock
);

    // Reset asserts immediately, releases two edges later.
    logic [1:0] rst_pipe;
    logic       rst_sync_n;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_pipe <= 2'b00;
        else           rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_sync_n = rst_pipe[1];

    logic [NUM_MON-1:0] qual;

    for (genvar i = 0; i < NUM_MON; i++) begin : g_filter
        accelerator_hls_deadlock_persist_filter #(
            .PERSIST (PERSIST)
        ) u_filter (
            .clk   (ap_clk),
            .rst_n (rst_sync_n),
            .clr   (clear),
            .in    (mon_block[i]),
            .qual  (qual[i])
        );
    end

    logic [TS_W-1:0] stamp;

`ifdef ACCEL_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] cycle_cnt;

    always_ff @(posedge ap_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) cycle_cnt <= '0;
        else             cycle_cnt <= cycle_cnt + TS_W'(1);
    end

    assign stamp = cycle_cnt;
`else
    assign stamp = '0;
`endif

    state_t state_q, state_d;
    logic   capture;
    rpt_t   cap_rec, rec_q;
    logic   valid_q, deadlock_q;

    always_ff @(posedge ap_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state_q <= ARMED;
        else             state_q <= state_d;
    end

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED:   if (clear) state_d = ARMED;
                     else if (|qual) state_d = REPORT;
            REPORT:  if (clear) state_d = ARMED;
                     else if (rpt_ready) state_d = HALT;
            HALT:    if (clear) state_d = ARMED;
            default: state_d = ARMED;
        endcase
    end

    always_comb begin
        capture           = (state_q == ARMED) && (|qual) && !clear;
        cap_rec.idx       = lowest_set(MAX_MON'(qual));
        cap_rec.mask      = MAX_MON'(qual);
        cap_rec.timestamp = stamp;
    end

    // Flags follow the next state so they are registered yet cycle-aligned with it.
    always_ff @(posedge ap_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rec_q      <= '0;
            valid_q    <= 1'b0;
            deadlock_q <= 1'b0;
        end else begin
            if (clear)        rec_q <= '0;
            else if (capture) rec_q <= cap_rec;
            valid_q    <= (state_d == REPORT);
            deadlock_q <= (state_d != ARMED);
        end
    end

    assign rpt_valid     = valid_q;
    assign deadlock      = deadlock_q;
    assign rpt_idx       = IDX_W'(rec_q.idx);
    assign rpt_mask      = NUM_MON'(rec_q.mask);
    assign rpt_timestamp = rec_q.timestamp;

endmodule

// File: tb/tb_accelerator_hls_deadlock_report_unit.sv
// Scoreboard bench for the deadlock report unit: a window model predicts each
// report, a negedge monitor compares whatever the unit presents.
module tb_accelerator_hls_deadlock_report_unit;

    localparam int NUM_MON = 4;
    localparam int PERSIST = 16;
    localparam int IDX_W   = 4;

    logic               ap_clk    = 1'b0;
    logic               ap_rst_n  = 1'b0;
    logic [NUM_MON-1:0] mon_block = '0;
    logic               clear     = 1'b0;
    logic               rpt_ready = 1'b0;
    logic               rpt_valid;
    logic [IDX_W-1:0]   rpt_idx;
    logic [NUM_MON-1:0] rpt_mask;
    logic [31:0]        rpt_timestamp;
    logic               deadlock;

    accelerator_hls_deadlock_report_unit #(
        .NUM_MON (NUM_MON),
        .PERSIST (PERSIST),
        .IDX_W   (IDX_W)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .mon_block     (mon_block),
        .clear         (clear),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_idx       (rpt_idx),
        .rpt_mask      (rpt_mask),
        .rpt_timestamp (rpt_timestamp),
        .deadlock      (deadlock)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [NUM_MON-1:0] mask;
        logic [31:0]        ts;
        int                 first_cyc;
    } exp_t;

    exp_t               exp_q[$];
    logic [NUM_MON-1:0] wave[$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 ts_base  = 0;
    logic               prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented report against the scoreboard head.
    always @(negedge ap_clk) begin
        if (rpt_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_report: rpt_valid=1 idx=%0d mask=%b, none expected (cycle %0d)",
                         rpt_idx, rpt_mask, cyc);
            end else begin
                if (!prev_valid) check("report_cycle", 64'(cyc), 64'(exp_q[0].first_cyc));
                check("rpt_idx", 64'(rpt_idx), 64'(exp_q[0].idx));
                check("rpt_mask", 64'(rpt_mask), 64'(exp_q[0].mask));
                check("rpt_timestamp", 64'(rpt_timestamp), 64'(exp_q[0].ts));
                check("deadlock_with_valid", 64'(deadlock), 64'd1);
                if (rpt_ready) void'(exp_q.pop_front());
            end
        end
        prev_valid = rpt_valid;
    end

    // A bit qualifies in cycle r when it was high for the PERSIST cycles before r.
    function automatic int first_qual(input int len, output logic [NUM_MON-1:0] m);
        logic [NUM_MON-1:0] w;
        m = '0;
        for (int r = PERSIST; r < len; r++) begin
            w = '1;
            for (int k = r - PERSIST; k < r; k++) w = w & wave[k];
            if (w != '0) begin
                m = w;
                return r;
            end
        end
        return -1;
    endfunction

    function automatic int lowest(input logic [NUM_MON-1:0] m);
        for (int i = 0; i < NUM_MON; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic build_const(input logic [NUM_MON-1:0] pat, input int len);
        wave.delete();
        for (int r = 0; r < len; r++) wave.push_back(pat);
    endtask

    task automatic build_random(input int len);
        logic [NUM_MON-1:0] tmp;
        wave.delete();
        for (int r = 0; r < len; r++) wave.push_back('0);
        for (int i = 0; i < NUM_MON; i++) begin
            int r   = 0;
            bit lvl = 1'($urandom_range(0, 1));
            while (r < len) begin
                int run = $urandom_range(1, PERSIST + 3);
                for (int k = 0; k < run && r < len; k++) begin
                    tmp     = wave[r];
                    tmp[i]  = lvl;
                    wave[r] = tmp;
                    r++;
                end
                lvl = !lvl;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(rpt_valid), 64'd0);
        check({tag, "_deadlock"}, 64'(deadlock), 64'd0);
        check({tag, "_idx"}, 64'(rpt_idx), 64'd0);
        check({tag, "_mask"}, 64'(rpt_mask), 64'd0);
        check({tag, "_timestamp"}, 64'(rpt_timestamp), 64'd0);
    endtask

    // Plays wave[] from counters-zero, stalls rpt_ready, then ends with clear.
    task automatic epoch(input int len, input int stall, input bit clr_on_hs);
        int                 base, q, hs, last, clear_r;
        logic [NUM_MON-1:0] m;
        exp_t               e;
        base = cyc;
        q    = first_qual(len, m);
        hs   = -1;
        if (q >= 0) begin
            hs     = q + 1 + stall;
            e.idx  = IDX_W'(lowest(m));
            e.mask = m;
`ifdef ACCEL_DEADLOCK_TIMESTAMP_EN
            e.ts   = 32'(base + q - ts_base);
`else
            e.ts   = 32'd0;
`endif
            e.first_cyc = base + q + 1;
            exp_q.push_back(e);
        end
        last    = (hs > len - 1) ? hs : len - 1;
        clear_r = (clr_on_hs && hs >= 0) ? hs : last + 1;
        for (int r = 0; r <= clear_r; r++) begin
            mon_block = (r < len) ? wave[r] : '0;
            rpt_ready = (hs >= 0 && r >= hs);
            clear     = (r == clear_r);
            if (r == 0) check("armed_deadlock", 64'(deadlock), 64'd0);
            if (hs >= 0 && r > hs) begin
                check("halt_valid", 64'(rpt_valid), 64'd0);
                check("halt_deadlock", 64'(deadlock), 64'd1);
            end
            @(posedge ap_clk);
            #1;
        end
        clear     = 1'b0;
        rpt_ready = 1'b0;
        check_idle("after_clear");
    endtask

    initial begin
        exp_t e;
        int   base;

        repeat (3) @(posedge ap_clk);
        #1;
        check_idle("in_reset");
        ap_rst_n = 1'b1;
        ts_base  = cyc + 2;
        repeat (4) @(posedge ap_clk);
        #1;

        // Single held bit, consumer always ready.
        build_const(4'b0100, PERSIST + 8);
        epoch(PERSIST + 8, 0, 1'b0);

        // One-cycle drop restarts the count.
        wave.delete();
        for (int r = 0; r < 15; r++) wave.push_back(4'b0010);
        wave.push_back(4'b0000);
        for (int r = 0; r < 24; r++) wave.push_back(4'b0010);
        epoch(40, 1, 1'b0);

        // Two bits qualify together, consumer stalls five cycles.
        build_const(4'b1010, 30);
        epoch(30, 5, 1'b0);

        // Clear on the handshake cycle, then the held bit re-reports.
        build_const(4'b0001, 30);
        epoch(30, 2, 1'b1);
        build_const(4'b0001, 30);
        epoch(30, 0, 1'b0);

        // Qualification lands exactly on the clear cycle: clear wins.
        build_const(4'b1111, PERSIST);
        epoch(PERSIST, 0, 1'b0);
        build_const(4'b0100, 20);
        epoch(20, 0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            int len = $urandom_range(20, 70);
            build_random(len);
            epoch(len, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Reset while a report is stalled in REPORT.
        base        = cyc;
        e.idx       = IDX_W'(2);
        e.mask      = 4'b0100;
`ifdef ACCEL_DEADLOCK_TIMESTAMP_EN
        e.ts        = 32'(base + PERSIST - ts_base);
`else
        e.ts        = 32'd0;
`endif
        e.first_cyc = base + PERSIST + 1;
        exp_q.push_back(e);
        mon_block = 4'b0100;
        rpt_ready = 1'b0;
        repeat (PERSIST + 3) @(posedge ap_clk);
        #1;
        check("valid_before_reset", 64'(rpt_valid), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(rpt_valid), 64'd0);
        check("async_reset_deadlock", 64'(deadlock), 64'd0);
        exp_q.delete();
        mon_block = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        ts_base  = cyc + 2;
        repeat (4) @(posedge ap_clk);
        #1;
        check_idle("after_reset");

        build_const(4'b0010, 24);
        epoch(24, 1, 1'b0);

        repeat (3) @(posedge ap_clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accelerator_hls_deadlock_report_unit.md
ACCELERATOR_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: accelerator_hls_deadlock_report_unit

Interface
REQ-001 Parameter NUM_MON, default 4: number of deadlock monitor block inputs, range 1..16.
REQ-002 Parameter PERSIST, default 16: consecutive cycles a block input must stay high before it counts, range 1..65535.
REQ-003 Parameter IDX_W, default 4: width of the reported monitor index.
REQ-004 Port ap_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port mon_block, input, NUM_MON bits: per-monitor block flags, already registered by the monitors.
REQ-007 Port clear, input, 1 bit: one-cycle pulse that re-arms the unit after a report.
REQ-008 Port rpt_valid, output, 1 bit: report record valid.
REQ-009 Port rpt_ready, input, 1 bit: report consumer ready.
REQ-010 Port rpt_idx, output, IDX_W bits: index of the reporting monitor.
REQ-011 Port rpt_mask, output, NUM_MON bits: snapshot of all qualified monitors at capture.
REQ-012 Port rpt_timestamp, output, 32 bits: cycle stamp at capture.
REQ-013 Port deadlock, output, 1 bit: sticky deadlock flag.

Function
REQ-014 Each monitor bit shall have a persistence counter: increment while mon_block[i]=1, saturate at PERSIST, reset to 0 in the same cycle the bit is low.
REQ-015 Bit i shall be qualified when its counter equals PERSIST, so a bit held high from cycle 0 qualifies at edge PERSIST.
REQ-016 A single-cycle drop on mon_block[i] shall restart its count from 0, with no hysteresis.
REQ-017 The FSM shall have three states: ARMED, REPORT and HALT, and shall reset to ARMED.
REQ-018 ARMED: when any bit is qualified, the unit shall capture rpt_idx (lowest qualified index), rpt_mask and rpt_timestamp, set deadlock, and go to REPORT on the next edge.
REQ-019 REPORT: rpt_valid shall be 1, and the payload shall stay stable until rpt_valid and rpt_ready are both high; on that handshake edge the FSM goes to HALT.
REQ-020 HALT: rpt_valid shall be 0, deadlock stays 1, and new qualifications shall be ignored and not queued.
REQ-021 clear in HALT or REPORT shall return the FSM to ARMED, drop rpt_valid, deadlock and the payload registers to 0, and zero all persistence counters in the same edge; an unaccepted report is discarded.
REQ-022 clear in ARMED shall only zero the persistence counters.
REQ-023 clear shall win over a simultaneous handshake or a simultaneous new qualification.
REQ-024 Outputs shall be registered; capture-to-rpt_valid latency is exactly 1 cycle after qualification.
REQ-025 rpt_idx shall be zero-extended to IDX_W; unused bits are 0.

Reset
REQ-026 While ap_rst_n=0, the FSM shall be ARMED, all counters 0, and rpt_valid, rpt_idx, rpt_mask, rpt_timestamp and deadlock 0.
REQ-027 Reset shall be asserted asynchronously and released synchronously through a 2-flop deassertion synchronizer, which is internal to this block.
REQ-028 Reset mid-REPORT shall drop rpt_valid immediately, with no handshake completion.

Configuration
REQ-029 With ACCEL_DEADLOCK_TIMESTAMP_EN defined, a free-running 32-bit cycle counter (reset 0, wraps 0xFFFFFFFF to 0) shall exist, and rpt_timestamp shall capture its value.
REQ-030 With ACCEL_DEADLOCK_TIMESTAMP_EN undefined, the counter shall not be built and rpt_timestamp shall be constant 0.

Structure
REQ-031 A shared package accelerator_hls_deadlock_pkg shall hold the FSM state typedef (ARMED, REPORT, HALT), the timestamp width constant 32, and the report record struct (idx, mask, timestamp).
REQ-032 The persistence counter shall be a sub-module, accelerator_hls_deadlock_persist_filter, instantiated NUM_MON times; its parameter is PERSIST and its ports are clk, rst_n, clr, in, qual.
REQ-033 Expected size is 150-300 lines of RTL in total.

Verification
REQ-034 Hold mon_block=4'b0100 from reset release, rpt_ready=1: rpt_valid shall pulse 1 cycle at cycle PERSIST+1, with rpt_idx=2, rpt_mask=4'b0100 and deadlock=1 sticky.
REQ-035 mon_block[1] high for 15 cycles, low 1 cycle, high 16 cycles (PERSIST=16): there shall be no report until 16 cycles after the re-rise.
REQ-036 mon_block=4'b1010 qualifying in the same cycle, rpt_ready=0 for 5 cycles: rpt_valid shall stay high with rpt_idx=1 and rpt_mask=4'b1010 stable; the handshake on cycle 6 leads to HALT.
REQ-037 clear on the same cycle as the rpt_ready handshake: the FSM shall go to ARMED, deadlock=0, and counters 0; a held block bit re-reports after PERSIST+1 cycles.
REQ-038 ap_rst_n asserted mid-REPORT: rpt_valid shall go 0 asynchronously, and all outputs shall be 0 after release.
REQ-039 With ACCEL_DEADLOCK_TIMESTAMP_EN defined and a qualify at cycle 20: rpt_timestamp=20; without the macro: rpt_timestamp=0.
